// File: rtl/cheat_pkg.sv
// Shared constants and types for the cheat-engine program loader.
// CHEAT_PGM_CHECKSUM_EN selects 6-byte frames that end in an XOR checksum byte.
package cheat_pkg;

   localparam logic [4:0] HDR_MAGIC  = 5'b10100;
   localparam logic [2:0] SLOT_MASK  = 3'd6;
   localparam logic [2:0] SLOT_FLAGS = 3'd7;

`ifdef CHEAT_PGM_CHECKSUM_EN
   localparam int unsigned FRAME_LEN = 6;
   localparam int unsigned CHK_BYTES = 1;
`else
   localparam int unsigned FRAME_LEN = 5;
   localparam int unsigned CHK_BYTES = 0;
`endif

   localparam int unsigned DATA_BYTES = FRAME_LEN - 1 - CHK_BYTES;
   // Without a checksum the final data byte is forwarded straight to pgm_in,
   // so the assembly register only needs to hold the bytes before it.
   localparam int unsigned ASM_W      = 8 * (DATA_BYTES - 1 + CHK_BYTES);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      CHECK,
      ISSUE
   } state_t;

endpackage

// File: rtl/cheat_pgm_loader_if.sv
// MCU byte-stream in / cheat-engine program port out, grouped as one bundle.
interface cheat_pgm_loader_if;

   logic [7:0]  mcu_data_in;
   logic        mcu_wr_strobe;
   logic        snescmd_wr_strobe;
   logic        err_clr;
   logic [2:0]  pgm_idx;
   logic        pgm_we;
   logic [31:0] pgm_in;
   logic        busy;
   logic        frame_err;
   logic        defer_ovf;

   modport master (
      output mcu_data_in, mcu_wr_strobe, snescmd_wr_strobe, err_clr,
      input  pgm_idx, pgm_we, pgm_in, busy, frame_err, defer_ovf
   );

   modport slave (
      input  mcu_data_in, mcu_wr_strobe, snescmd_wr_strobe, err_clr,
      output pgm_idx, pgm_we, pgm_in, busy, frame_err, defer_ovf
   );

endinterface

// File: rtl/cheat_pgm_timeout.sv
// Saturating idle counter for MCU byte-stream parsers: counts while enabled,
// restarts on activity, flags expiry after TIMEOUT_CYCLES-1 quiet cycles.
module cheat_pgm_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic restart,
   output logic expire
);

   localparam int unsigned   W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [W-1:0]  LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!enable || restart) begin
         cnt_d = '0;
      end else if (cnt_q != LAST) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Activity in the expiry cycle wins, so restart masks expire.
   assign expire = enable && !restart && (cnt_q == LAST);

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of its peers regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cheat_pgm_loader.sv
// Assembles MCU header+data frames into 32-bit cheat-engine program words,
// deferring the write around SNES snescmd writes. Option: CHEAT_PGM_CHECKSUM_EN.
module cheat_pgm_loader
   import cheat_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned MAX_DEFER      = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   cheat_pgm_loader_if.slave bus
);

   localparam int unsigned  DW         = $clog2(MAX_DEFER + 1);
   localparam logic [DW-1:0] DEFER_LAST = DW'(MAX_DEFER);
   localparam logic [1:0]   LAST_BYTE  = 2'(DATA_BYTES - 1);

   state_t             state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [ASM_W-1:0]   asm_q, asm_d;
   logic [DW-1:0]      defer_q, defer_d;
   logic [2:0]         pgm_idx_q, pgm_idx_d;
   logic [31:0]        pgm_in_q, pgm_in_d;
   logic               frame_err_q, frame_err_d;
   logic               defer_ovf_q, defer_ovf_d;
`ifdef CHEAT_PGM_CHECKSUM_EN
   logic [7:0]         chk_q, chk_d;
`endif

   logic pgm_we;
   logic err_set;
   logic ovf_set;
   logic tmo_en;
   logic tmo_expire;

   assign tmo_en = (state_q == DATA) || (state_q == CHECK);

   cheat_pgm_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (tmo_en),
      .restart (bus.mcu_wr_strobe),
      .expire  (tmo_expire)
   );

   // NOTE: every value written below gets its default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      asm_d     = asm_q;
      defer_d   = defer_q;
      pgm_idx_d = pgm_idx_q;
      pgm_in_d  = pgm_in_q;
`ifdef CHEAT_PGM_CHECKSUM_EN
      chk_d     = chk_q;
`endif
      pgm_we    = 1'b0;
      err_set   = 1'b0;
      ovf_set   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.mcu_wr_strobe) begin
               if (bus.mcu_data_in[7:3] == HDR_MAGIC) begin
                  idx_d   = bus.mcu_data_in[2:0];
                  cnt_d   = '0;
                  state_d = DATA;
`ifdef CHEAT_PGM_CHECKSUM_EN
                  chk_d   = bus.mcu_data_in;
`endif
               end else begin
                  err_set = 1'b1;
               end
            end
         end

         DATA: begin
            if (bus.mcu_wr_strobe) begin
               asm_d = ASM_W'({asm_q, bus.mcu_data_in});
               if (cnt_q == LAST_BYTE) begin
`ifdef CHEAT_PGM_CHECKSUM_EN
                  chk_d     = chk_q ^ bus.mcu_data_in;
                  state_d   = CHECK;
`else
                  pgm_idx_d = idx_q;
                  pgm_in_d  = {asm_q, bus.mcu_data_in};
                  state_d   = ISSUE;
`endif
               end else begin
                  cnt_d = cnt_q + 1'b1;
`ifdef CHEAT_PGM_CHECKSUM_EN
                  chk_d = chk_q ^ bus.mcu_data_in;
`endif
               end
            end else if (tmo_expire) begin
               err_set = 1'b1;
               state_d = IDLE;
            end
         end

`ifdef CHEAT_PGM_CHECKSUM_EN
         CHECK: begin
            if (bus.mcu_wr_strobe) begin
               if (bus.mcu_data_in == chk_q) begin
                  pgm_idx_d = idx_q;
                  pgm_in_d  = asm_q;
                  state_d   = ISSUE;
               end else begin
                  err_set = 1'b1;
                  state_d = IDLE;
               end
            end else if (tmo_expire) begin
               err_set = 1'b1;
               state_d = IDLE;
            end
         end
`endif

         ISSUE: begin
            // The MCU must wait for busy to drop; a byte arriving now is lost.
            if (bus.mcu_wr_strobe) begin
               err_set = 1'b1;
            end
            if (!bus.snescmd_wr_strobe || (defer_q == DEFER_LAST)) begin
               pgm_we  = 1'b1;
               ovf_set = bus.snescmd_wr_strobe;
               defer_d = '0;
               state_d = IDLE;
            end else begin
               defer_d = defer_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase

      // A new error in the same cycle as err_clr keeps the flag set.
      frame_err_d = err_set | (frame_err_q & ~bus.err_clr);
      defer_ovf_d = ovf_set | (defer_ovf_q & ~bus.err_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         asm_q       <= '0;
         defer_q     <= '0;
         pgm_idx_q   <= '0;
         pgm_in_q    <= '0;
         frame_err_q <= 1'b0;
         defer_ovf_q <= 1'b0;
`ifdef CHEAT_PGM_CHECKSUM_EN
         chk_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         asm_q       <= asm_d;
         defer_q     <= defer_d;
         pgm_idx_q   <= pgm_idx_d;
         pgm_in_q    <= pgm_in_d;
         frame_err_q <= frame_err_d;
         defer_ovf_q <= defer_ovf_d;
`ifdef CHEAT_PGM_CHECKSUM_EN
         chk_q       <= chk_d;
`endif
      end
   end

   assign bus.pgm_idx   = pgm_idx_q;
   assign bus.pgm_in    = pgm_in_q;
   assign bus.pgm_we    = pgm_we;
   assign bus.busy      = (state_q != IDLE);
   assign bus.frame_err = frame_err_q;
   assign bus.defer_ovf = defer_ovf_q;

endmodule

// File: tb/tb_cheat_pgm_loader.sv
// Directed self-checking bench for cheat_pgm_loader (either frame format).
module tb_cheat_pgm_loader;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   we_total;

   cheat_pgm_loader_if bus ();

   cheat_pgm_loader #(
      .TIMEOUT_CYCLES (4096),
      .MAX_DEFER      (15)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.pgm_we === 1'b1) we_total++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.mcu_data_in   = b;
      bus.mcu_wr_strobe = 1'b1;
      cyc();
      bus.mcu_wr_strobe = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] hdr, input logic [31:0] w);
      send_byte(hdr);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
`ifdef CHEAT_PGM_CHECKSUM_EN
      send_byte(hdr ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
`endif
   endtask

   task automatic clr_err();
      bus.err_clr = 1'b1;
      cyc();
      bus.err_clr = 1'b0;
   endtask

   // Called in the cycle the write is due: pulse now, gone next cycle.
   task automatic expect_issue(input string tag, input logic [2:0] idx, input logic [31:0] w);
      @(negedge clk);
      check({tag, "_we"},   32'(bus.pgm_we), 32'd1);
      check({tag, "_idx"},  32'(bus.pgm_idx), 32'(idx));
      check({tag, "_in"},   bus.pgm_in, w);
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      cyc();
      @(negedge clk);
      check({tag, "_we_drop"}, 32'(bus.pgm_we), 32'd0);
      check({tag, "_idle"},    32'(bus.busy), 32'd0);
      check({tag, "_hold"},    bus.pgm_in, w);
   endtask

   initial begin
      int we_at;
      int we_cnt;
      int w0;

      n_checks = 0;
      n_fail   = 0;
      we_total = 0;
      rst_n                 = 1'b0;
      bus.mcu_data_in       = 8'h00;
      bus.mcu_wr_strobe     = 1'b0;
      bus.snescmd_wr_strobe = 1'b0;
      bus.err_clr           = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_idx",  32'(bus.pgm_idx), 32'd0);
      check("rst_we",   32'(bus.pgm_we), 32'd0);
      check("rst_in",   bus.pgm_in, 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_ferr", 32'(bus.frame_err), 32'd0);
      check("rst_dovf", 32'(bus.defer_ovf), 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // Plain frame, no conflict: write in the cycle after the last byte.
      send_frame(8'hA1, 32'h1234569A);
      expect_issue("a1", 3'd1, 32'h1234569A);
      check("a1_ferr", 32'(bus.frame_err), 32'd0);

      // Conflict for 3 cycles, write lands on the 4th.
      cyc();
      send_frame(8'hA7, 32'h0000000F);
      bus.snescmd_wr_strobe = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check($sformatf("a7_defer%0d_we", k), 32'(bus.pgm_we), 32'd0);
         check($sformatf("a7_defer%0d_busy", k), 32'(bus.busy), 32'd1);
         cyc();
      end
      bus.snescmd_wr_strobe = 1'b0;
      expect_issue("a7", cheat_pkg::SLOT_FLAGS, 32'h0000000F);
      check("a7_dovf", 32'(bus.defer_ovf), 32'd0);

      // Conflict held 20 cycles: write forced after 15 deferrals.
      cyc();
      send_frame(8'hA6, 32'hDEADBEEF);
      bus.snescmd_wr_strobe = 1'b1;
      we_at  = 0;
      we_cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.pgm_we === 1'b1) begin
            we_cnt++;
            if (we_at == 0) we_at = k;
         end
         cyc();
      end
      bus.snescmd_wr_strobe = 1'b0;
      @(negedge clk);
      check("force_cycle", 32'(we_at), 32'd16);
      check("force_count", 32'(we_cnt), 32'd1);
      check("force_idx",   32'(bus.pgm_idx), 32'(cheat_pkg::SLOT_MASK));
      check("force_in",    bus.pgm_in, 32'hDEADBEEF);
      check("force_dovf",  32'(bus.defer_ovf), 32'd1);
      check("force_busy",  32'(bus.busy), 32'd0);
      clr_err();
      @(negedge clk);
      check("dovf_clr", 32'(bus.defer_ovf), 32'd0);

      // Bad header together with err_clr: the error wins.
      cyc();
      w0 = we_total;
      bus.err_clr = 1'b1;
      send_byte(8'h55);
      bus.err_clr = 1'b0;
      @(negedge clk);
      check("bad_hdr_ferr", 32'(bus.frame_err), 32'd1);
      check("bad_hdr_busy", 32'(bus.busy), 32'd0);
      check("bad_hdr_nowe", 32'(we_total), 32'(w0));
      cyc();
      send_frame(8'hA0, 32'h00FFEA2B);
      expect_issue("a0", 3'd0, 32'h00FFEA2B);
      check("ferr_sticky", 32'(bus.frame_err), 32'd1);
      clr_err();
      @(negedge clk);
      check("ferr_clr", 32'(bus.frame_err), 32'd0);

      // Byte arriving while the write is deferred is dropped and flagged.
      cyc();
      send_frame(8'hA5, 32'hCAFEBABE);
      bus.snescmd_wr_strobe = 1'b1;
      bus.mcu_data_in       = 8'h77;
      bus.mcu_wr_strobe     = 1'b1;
      cyc();
      bus.mcu_wr_strobe     = 1'b0;
      bus.snescmd_wr_strobe = 1'b0;
      expect_issue("a5", 3'd5, 32'hCAFEBABE);
      check("issue_strobe_ferr", 32'(bus.frame_err), 32'd1);
      clr_err();

      // Header plus 2 bytes then silence: abort exactly after 4096 idle cycles.
      w0 = we_total;
      send_byte(8'hA3);
      send_byte(8'h11);
      send_byte(8'h22);
      repeat (4095) cyc();
      @(negedge clk);
      check("tmo_before_busy", 32'(bus.busy), 32'd1);
      check("tmo_before_ferr", 32'(bus.frame_err), 32'd0);
      cyc();
      @(negedge clk);
      check("tmo_busy", 32'(bus.busy), 32'd0);
      check("tmo_ferr", 32'(bus.frame_err), 32'd1);
      check("tmo_nowe", 32'(we_total), 32'(w0));
      clr_err();
      send_frame(8'hA4, 32'h01020304);
      expect_issue("a4", 3'd4, 32'h01020304);

      // Reset mid-frame: partial frame discarded, trailing bytes are bad headers.
      cyc();
      w0 = we_total;
      send_byte(8'hA1);
      send_byte(8'h11);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_in",   bus.pgm_in, 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();
      send_byte(8'h22);
      send_byte(8'h33);
      repeat (3) cyc();
      @(negedge clk);
      check("mid_rst_nowe", 32'(we_total), 32'(w0));
      check("mid_rst_ferr", 32'(bus.frame_err), 32'd1);
      clr_err();

`ifdef CHEAT_PGM_CHECKSUM_EN
      // A2^7E^00^10^FF = 33.
      cyc();
      send_byte(8'hA2);
      send_byte(8'h7E);
      send_byte(8'h00);
      send_byte(8'h10);
      send_byte(8'hFF);
      send_byte(8'h33);
      expect_issue("chk_ok", 3'd2, 32'h7E0010FF);
      cyc();
      w0 = we_total;
      send_byte(8'hA2);
      send_byte(8'h7E);
      send_byte(8'h00);
      send_byte(8'h10);
      send_byte(8'hFF);
      send_byte(8'h34);
      @(negedge clk);
      check("chk_bad_ferr", 32'(bus.frame_err), 32'd1);
      check("chk_bad_busy", 32'(bus.busy), 32'd0);
      repeat (2) cyc();
      check("chk_bad_nowe", 32'(we_total), 32'(w0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
